// File: rtl/rom_bus_if_if.sv
// Multiplexed 4-bit CPU bus as seen by a program ROM: CPU phase strobes in, ROM drive out.
// The ROM owns the bus only in a cycle where drive_en is high; otherwise drive_o must be ignored.
interface rom_bus_if_if;
  logic       sync;
  logic       rom_cmd;
  logic [3:0] bus_i;
  logic [3:0] drive_o;
  logic       drive_en;

  modport master (
    output sync,
    output rom_cmd,
    output bus_i,
    input  drive_o,
    input  drive_en
  );

  modport slave (
    input  sync,
    input  rom_cmd,
    input  bus_i,
    output drive_o,
    output drive_en
  );
endinterface

// File: rtl/rom_bus_if.sv
// 4001-style program ROM emulator: tracks the 8-phase cycle from sync and drives OPR/OPA in M1/M2.
// Optional ROM output port (SRC/WRR snooping) is built when ROM_IO_PORT_EN is defined.
module rom_bus_if #(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter int         DEPTH   = 16,
  parameter int         ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  rom_bus_if_if.slave       bus,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [3:0]        io_port_o,
  output logic [3:0]        phase_o,
  output logic              sel_o
);

  typedef enum logic [3:0] {
    IDLE, A1, A2, A3, M1, M2, X1, X2, X3
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [7:0]  addr_q, addr_d;
  logic        sel_q, sel_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  drive_o_q, drive_o_d;
  logic        drive_en_q, drive_en_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [7:0]  fetch_byte;
  logic        chip_match;

  assign chip_match = (bus.bus_i == CHIP_ID);

  always_comb begin
    phase_d    = phase_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    opa_d      = opa_q;
    drive_o_d  = 4'h0;
    drive_en_d = 1'b0;
    fetch_byte = 8'h00;
    mem_d      = mem_q;

    // Addresses beyond the store fetch a NOP instead of aliasing onto low bytes.
    if ((addr_q >> ADDR_W) == 8'd0) fetch_byte = mem_q[addr_q[ADDR_W-1:0]];

    case (phase_q)
      IDLE:    phase_d = IDLE;
      A1:      phase_d = A2;
      A2:      phase_d = A3;
      A3:      phase_d = M1;
      M1:      phase_d = M2;
      M2:      phase_d = X1;
      X1:      phase_d = X2;
      X2:      phase_d = X3;
      X3:      phase_d = IDLE;
      default: phase_d = IDLE;
    endcase

    case (phase_q)
      A1: addr_d[3:0] = bus.bus_i;
      A2: addr_d[7:4] = bus.bus_i;
      A3: begin
        sel_d      = chip_match;
        opa_d      = fetch_byte[3:0];
        drive_o_d  = fetch_byte[7:4];
        drive_en_d = chip_match;
      end
      M1: begin
        drive_o_d  = opa_q;
        drive_en_d = drive_en_q;
      end
      default: ;
    endcase

    // Sync resynchronises from any phase and abandons a fetch in flight.
    if (bus.sync) begin
      phase_d    = A1;
      drive_o_d  = 4'h0;
      drive_en_d = 1'b0;
    end

    // mem_q is read above before this write lands, so a same-edge write returns the old byte.
    if (load_we) mem_d[load_addr] = load_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= IDLE;
      addr_q     <= 8'h00;
      sel_q      <= 1'b0;
      opa_q      <= 4'h0;
      drive_o_q  <= 4'h0;
      drive_en_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      opa_q      <= opa_d;
      drive_o_q  <= drive_o_d;
      drive_en_q <= drive_en_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.drive_o  = drive_o_q;
  assign bus.drive_en = drive_en_q;
  assign phase_o      = phase_q;
  assign sel_o        = sel_q;

`ifdef ROM_IO_PORT_EN
  logic       io_sel_q, io_sel_d;
  logic       io_pend_q, io_pend_d;
  logic [3:0] io_port_q, io_port_d;

  // io_pend marks a WRR fetched by any chip; the port updates at X2 only if this chip was SRC-selected.
  always_comb begin
    io_sel_d  = io_sel_q;
    io_pend_d = io_pend_q;
    io_port_d = io_port_q;
    case (phase_q)
      M2: if (bus.rom_cmd) io_pend_d = (bus.bus_i == 4'h2);
      X2: begin
        if (io_pend_q && io_sel_q) io_port_d = bus.bus_i;
        if (bus.rom_cmd) io_sel_d = chip_match;
      end
      X3: io_pend_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_sel_q  <= 1'b0;
      io_pend_q <= 1'b0;
      io_port_q <= 4'h0;
    end else begin
      io_sel_q  <= io_sel_d;
      io_pend_q <= io_pend_d;
      io_port_q <= io_port_d;
    end
  end

  assign io_port_o = io_port_q;
`else
  logic unused_rom_cmd;
  assign unused_rom_cmd = bus.rom_cmd;
  assign io_port_o      = 4'h0;
`endif

endmodule
